// File: rtl/sync_debounce_pkg.sv
// Shared helpers for the sync_debounce input conditioner.
// Holds the debounce counter width rule so every channel sizes its counter the same way.
package sync_debounce_pkg;

  // A single-tick filter still needs one counter bit to stay a legal vector.
  function automatic int cnt_width(input int ticks);
    int w;
    w = $clog2(ticks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel of the conditioner: synchronizer chain, debounce counter,
// registered level and registered single-cycle rise/fall pulses.
module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES    = 3,
  parameter int   DEBOUNCE_TICKS = 4,
  parameter logic RESET_BIT      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic in_bit,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_bit};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any return to the current level wipes the partial count, even without tick.
    if (sync_bit == level_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_bit;
        cnt_d   = '0;
        rise_d  = sync_bit;
        fall_d  = ~sync_bit;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{RESET_BIT}};
      cnt_q   <= '0;
      level_q <= RESET_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer plus debounce filter with edge pulses.
// Pure fan-out wrapper: each bit is handled by an independent debounce_channel.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int               WIDTH          = 1,
  parameter int               SYNC_STAGES    = 3,
  parameter int               DEBOUNCE_TICKS = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .RESET_BIT     (RESET_VALUE[i])
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .in_bit(in[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: stimulus pushes the reference model's
// per-cycle expectation, an independent monitor pops and compares after each edge.
module tb_sync_debounce;

  localparam int           W    = 4;
  localparam int           SS   = 3;
  localparam int           DT   = 4;
  localparam logic [W-1:0] RV   = 4'b0101;
  localparam int           MAXC = 16384;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick;
  logic [W-1:0] in_v;
  logic [W-1:0] level, rise, fall;

  always #5 clk = ~clk;

  sync_debounce #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_TICKS(DT), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .in(in_v),
    .level(level), .rise(rise), .fall(fall)
  );

  typedef struct packed {
    logic [W-1:0] lvl;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, got, want, $time);
    end
  endtask

  // Reference model: a delay line stands in for the synchronizer; a new level is
  // accepted when the qualified samples since sync last agreed with level reach DT.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] m_lvl;
  logic [W-1:0] s_hist[MAXC];
  bit           t_hist[MAXC];
  int           m_n;

  task automatic model_reset();
    m_pipe.delete();
    for (int k = 0; k < SS; k++) m_pipe.push_back(RV);
    m_lvl = RV;
    m_n   = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] din, input bit tk, output exp_t e);
    logic [W-1:0] s;
    int           qual;
    if (m_n >= MAXC) begin
      $display("FAIL model_depth: got %0d want <%0d", m_n, MAXC);
      $fatal(1, "model history exhausted");
    end
    s = m_pipe.pop_front();
    m_pipe.push_back(din);
    s_hist[m_n] = s;
    t_hist[m_n] = tk;
    e.rs = '0;
    e.fl = '0;
    for (int ch = 0; ch < W; ch++) begin
      if (tk && s[ch] != m_lvl[ch]) begin
        qual = 0;
        for (int m = m_n; m >= 0 && s_hist[m][ch] != m_lvl[ch]; m--)
          qual += int'(t_hist[m]);
        if (qual >= DT) begin
          m_lvl[ch] = s[ch];
          if (s[ch]) e.rs[ch] = 1'b1;
          else       e.fl[ch] = 1'b1;
        end
      end
    end
    e.lvl = m_lvl;
    m_n++;
  endtask

  // One clock of stimulus, applied at the falling edge.
  task automatic step(input logic [W-1:0] d, input bit tk, input bit rs);
    exp_t e;
    in_v  = d;
    tick  = tk;
    reset = rs;
    if (rs) begin
      model_reset();
      e.lvl = RV;
      e.rs  = '0;
      e.fl  = '0;
    end else begin
      model_edge(d, tk, e);
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("level", 32'(level), 32'(e.lvl));
      check("rise",  32'(rise),  32'(e.rs));
      check("fall",  32'(fall),  32'(e.fl));
    end
  end

  // Edges from the capture edge (counted as 1) until the pulse shows on channel ch.
  task automatic measure(input logic [W-1:0] d, input int ch, input bit want_rise,
                         input string nm);
    int found;
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      step(d, 1'b1, 1'b0);
      if (want_rise ? rise[ch] : fall[ch]) found = k;
    end
    check(nm, 32'(found), 32'(SS + DT));
  endtask

  initial begin
    logic [W-1:0] cur;
    bit           tk;
    int           tick_pct;
    reset = 1'b1;
    tick  = 1'b1;
    in_v  = RV;
    cur   = RV;
    model_reset();
    @(negedge clk);

    // Reset with inputs at the reset value: no pulses for 20 cycles.
    repeat (3) step(cur, 1'b1, 1'b1);
    repeat (20) step(cur, 1'b1, 1'b0);

    // Latency on a clean rising and falling step.
    cur[1] = 1'b1;
    measure(cur, 1, 1'b1, "lat_rise");
    repeat (3) step(cur, 1'b1, 1'b0);
    cur[0] = 1'b0;
    measure(cur, 0, 1'b0, "lat_fall");
    repeat (3) step(cur, 1'b1, 1'b0);

    // Glitch shorter than DT is rejected; a DT-wide pulse is accepted.
    cur[3] = 1'b1;
    repeat (3) step(cur, 1'b1, 1'b0);
    cur[3] = 1'b0;
    repeat (10) step(cur, 1'b1, 1'b0);
    cur[3] = 1'b1;
    repeat (4) step(cur, 1'b1, 1'b0);
    cur[3] = 1'b0;
    repeat (12) step(cur, 1'b1, 1'b0);

    // Tick gated to one cycle in ten, then tick held low.
    cur[3] = 1'b1;
    for (int k = 0; k < 80; k++) step(cur, (k % 10) == 0, 1'b0);
    cur[3] = 1'b0;
    repeat (60) step(cur, 1'b0, 1'b0);
    repeat (10) step(cur, 1'b1, 1'b0);

    // Channel independence: rise on 1 and fall on 2 from the same edge.
    cur[1] = 1'b0;
    repeat (10) step(cur, 1'b1, 1'b0);
    cur[1] = 1'b1;
    cur[2] = 1'b0;
    repeat (10) step(cur, 1'b1, 1'b0);

    // Reset part way through a count discards it.
    cur[1] = 1'b0;
    repeat (10) step(cur, 1'b1, 1'b0);
    cur[1] = 1'b1;
    repeat (SS + 2) step(cur, 1'b1, 1'b0);
    step(cur, 1'b1, 1'b1);
    repeat (15) step(cur, 1'b1, 1'b0);

    // Randomized traffic with mixed tick density and occasional resets.
    tick_pct = 100;
    for (int k = 0; k < 2000; k++) begin
      if (k % 200 == 0) tick_pct = ($urandom_range(0, 1) == 0) ? 100 : 50;
      if ($urandom_range(0, 5) == 0) cur[$urandom_range(0, W - 1)] ^= 1'b1;
      tk = ($urandom_range(1, 100) <= tick_pct);
      step(cur, tk, ($urandom_range(0, 399) == 0));
    end

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
